// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : types and constants shared by the 8-bit UART transmitter/receiver
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } uart_rx_state_t;

  function automatic logic parity_bit(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart8_receiver_if.sv
// ============================================================================
// uart8_receiver_if : serial line / peripheral-bus signals of the UART receiver
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart8_receiver_if;
  import uart_pkg::*;

  logic                   en;
  logic                   in;
  logic [UART_DATA_W-1:0] out;
  logic                   done;
  logic                   busy;
  logic                   frame_err;
  logic                   parity_err;

  modport master (
    input  en, in,
    output out, done, busy, frame_err, parity_err
  );

  modport slave (
    output en, in,
    input  out, done, busy, frame_err, parity_err
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync : two-flop synchronizer for the asynchronous rx line, resets high
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/uart8_receiver.sv
// ============================================================================
// uart8_receiver : oversampling 8N1 UART receiver with one-cycle done pulse.
//                  Define UART_RX_PARITY_EN for 8 data + parity + stop frames.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart8_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input wire logic          clk,
  input wire logic          rst_n,
  uart8_receiver_if.master  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] c_half = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] c_last = TW'(OVERSAMPLE - 1);

  uart_rx_state_t         r_state;
  logic [TW-1:0]          r_tick;
  logic [2:0]             r_bit;
  logic [UART_DATA_W-1:0] r_shreg;
  logic [UART_DATA_W-1:0] r_out;
  logic                   r_armed;
  logic                   r_done;
  logic                   r_busy;
  logic                   r_frame_err;
  logic                   w_rx_s;
`ifdef UART_RX_PARITY_EN
  logic                   r_par_mis;
  logic                   r_parity_err;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.in),
    .q     (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shreg     <= '0;
      r_out       <= '0;
      r_armed     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_mis    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (w_rx_s) r_armed <= 1'b1;
          // armed blocks a restart while the line is held low (break)
          if (bus.en && r_armed && !w_rx_s) begin
            r_state <= START_BIT;
            r_tick  <= '0;
            r_armed <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START_BIT: begin
          if (r_tick == c_half) begin
            r_tick <= '0;
            if (!w_rx_s) begin
              r_state <= DATA_BITS;
              r_bit   <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        DATA_BITS: begin
          if (r_tick == c_last) begin
            r_tick  <= '0;
            r_shreg <= {w_rx_s, r_shreg[UART_DATA_W-1:1]};
            if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY_BIT;
`else
              r_state <= STOP_BIT;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        PARITY_BIT: begin
`ifdef UART_RX_PARITY_EN
          if (r_tick == c_last) begin
            r_tick    <= '0;
            r_par_mis <= (w_rx_s != parity_bit(r_shreg, PARITY_ODD));
            r_state   <= STOP_BIT;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
`else
          r_state <= IDLE;
          r_busy  <= 1'b0;
`endif
        end
        STOP_BIT: begin
          if (r_tick == c_last) begin
            r_tick      <= '0;
            r_out       <= r_shreg;
            r_done      <= 1'b1;
            r_frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= r_par_mis;
`endif
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  // no parity field in 8N1 frames; the flag is held low
  assign bus.parity_err = PARITY_ODD & 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart8_receiver.sv
// ============================================================================
// tb_uart8_receiver : directed frames against a frame-level expectation queue
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart8_receiver;

  localparam int OS   = 16;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS   = 11;
  localparam int LAT_LIT = 170;
`else
  localparam int NBITS   = 10;
  localparam int LAT_LIT = 154;
`endif
  // done follows the first low sample by sync delay + half bit + remaining bits
  localparam int LAT = 2 + OS / 2 + (NBITS - 1) * OS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart8_receiver_if bus ();

  uart8_receiver #(.OVERSAMPLE(OS), .PARITY_ODD(PODD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   done_cnt = 0;
  int   last_done_cyc = 0;
  bit   busy_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) busy_seen = 1'b1;
      if (bus.done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (q.size() > 0 && cyc == q[0].due) begin
        check("done_at_due", bus.done, 1);
        check("out", bus.out, q[0].data);
        check("frame_err", bus.frame_err, q[0].ferr);
        check("parity_err", bus.parity_err, q[0].perr);
        void'(q.pop_front());
      end else begin
        check("done_quiet", bus.done, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.in = b;
    idle(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit accept,
                            input logic flip);
    if (accept) q.push_back('{due: cyc + 1 + LAT, data: d, ferr: ~stop, perr: flip});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PODD ^ flip);
`endif
    drive_bit(stop);
  endtask

  initial begin
    int t0;
    int d0;
    bus.en = 1'b1;
    bus.in = 1'b1;
    rst_n  = 1'b0;
    idle(3);
    check("rst_out", bus.out, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_parity_err", bus.parity_err, 0);
    rst_n = 1'b1;
    idle(20);

    // back-to-back valid frames
    t0 = cyc + 1;
    send_frame(8'hA5, 1'b1, 1, 1'b0);
    check("latency_A5", last_done_cyc - t0, LAT_LIT);
    check("out_A5", bus.out, 8'hA5);
    check("ferr_A5", bus.frame_err, 0);
    send_frame(8'h3C, 1'b1, 1, 1'b0);
    idle(20);
    check("out_3C", bus.out, 8'h3C);
    check("ferr_3C", bus.frame_err, 0);
    check("done_count_2", done_cnt, 2);

    // bad stop bit, line held low afterwards
    send_frame(8'h3C, 1'b0, 1, 1'b0);
    idle(40);
    check("break_busy", bus.busy, 0);
    check("break_ferr", bus.frame_err, 1);
    check("break_out", bus.out, 8'h3C);
    check("done_count_3", done_cnt, 3);
    bus.in = 1'b1;
    idle(20);

    // false start: 4 low cycles
    bus.in = 1'b0;
    idle(4);
    check("false_start_busy", bus.busy, 1);
    bus.in = 1'b1;
    idle(20);
    check("false_start_idle", bus.busy, 0);
    check("false_start_ferr", bus.frame_err, 1);
    check("false_start_out", bus.out, 8'h3C);
    check("false_start_done", done_cnt, 3);

    send_frame(8'h01, 1'b1, 1, 1'b0);
    idle(20);
    check("out_01", bus.out, 8'h01);
    check("ferr_01", bus.frame_err, 0);

    // reset during data bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    idle(OS / 2);
    check("pre_rst_busy", bus.busy, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    idle(1);
    check("mid_rst_out", bus.out, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_ferr", bus.frame_err, 0);
    rst_n = 1'b1;
    idle(OS * 6);
    check("mid_rst_no_done", done_cnt, d0);
    send_frame(8'h81, 1'b1, 1, 1'b0);
    idle(20);
    check("out_81", bus.out, 8'h81);

    // receiver disabled for a whole frame
    bus.en    = 1'b0;
    busy_seen = 1'b0;
    d0        = done_cnt;
    send_frame(8'h55, 1'b1, 0, 1'b0);
    idle(20);
    check("en0_busy", busy_seen, 0);
    check("en0_done", done_cnt, d0);
    check("en0_out", bus.out, 8'h81);

    // enable dropped after the frame has started
    bus.en = 1'b1;
    fork
      send_frame(8'h55, 1'b1, 1, 1'b0);
      begin
        repeat (24) @(posedge clk);
        #2 bus.en = 1'b0;
      end
    join
    idle(20);
    check("en_drop_out", bus.out, 8'h55);
    check("en_drop_done", done_cnt, d0 + 1);
    bus.en = 1'b1;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1, 1'b0);
    idle(20);
    check("par_ok", bus.parity_err, 0);
    send_frame(8'h07, 1'b1, 1, 1'b1);
    idle(20);
    check("par_bad", bus.parity_err, 1);
`endif

    for (int i = 0; i < 400 && q.size() > 0; i++) idle(1);
    check("pending_frames", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
